memory_pipelined: RTL and testbench

Parametrised dual-port byte-addressed RAM for the SoC. Port I serves instruction fetch and is read-only, word access only. Port D serves load/store and is read/write with BYTE/HALFWORD/WORD sizes. Both ports use a request/response protocol with a configurable read latency, plus per-transaction error responses for misaligned and out-of-range accesses.

---
 rtl/memory_pipelined_pkg.sv | 42 ++++
 rtl/memory_pipelined_rsp_pipe.sv | 49 ++++
 rtl/memory_pipelined.sv | 137 +++++++++++++
 tb/tb_memory_pipelined.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_pipelined_pkg.sv
// rtl/memory_pipelined_pkg.sv - shared SoC types and access-check helpers
//
// Purpose: transfer-size enum, byte-count helper and the alignment/range
// check used by the memory and by other bus slaves.
package memory_pipelined_pkg;

  typedef enum logic [1:0] {
    BYTE     = 2'd0,
    HALFWORD = 2'd1,
    WORD     = 2'd2
  } tsize_e;

  // Byte count of a transfer; 0 for an encoding outside the enum.
  function automatic logic [2:0] size_bytes(input tsize_e sz);
    logic [2:0] n;
    case (sz)
      BYTE:     n = 3'd1;
      HALFWORD: n = 3'd2;
      WORD:     n = 3'd4;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

  // 1 when the access is misaligned, runs past n_bytes, or has an illegal size.
  // The end address is formed in 65 bits so it can never wrap.
  function automatic logic access_err(input logic [63:0] addr,
                                      input tsize_e      sz,
                                      input logic [63:0] n_bytes);
    logic        bad;
    logic [64:0] end_excl;
    case (sz)
      BYTE:     bad = 1'b0;
      HALFWORD: bad = addr[0];
      WORD:     bad = |addr[1:0];
      default:  bad = 1'b1;
    endcase
    end_excl = {1'b0, addr} + 65'(size_bytes(sz));
    return bad || (end_excl > {1'b0, n_bytes});
  endfunction

endpackage

// File: rtl/memory_pipelined_rsp_pipe.sv
// rtl/memory_pipelined_rsp_pipe.sv - fixed-latency response pipeline
//
// Purpose: LATENCY-deep shift of {valid, err, data}. Stage 0 loads on every
// edge; the last stage drives the outputs. rst clears every stage.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   i_valid, i_err, i_data      response entering stage 0
//   o_valid, o_err, o_data      response leaving the final stage
module mem_rsp_pipe #(
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic        i_err,
  input  logic [31:0] i_data,
  output logic        o_valid,
  output logic        o_err,
  output logic [31:0] o_data
);

  logic [LATENCY-1:0] r_valid;
  logic [LATENCY-1:0] r_err;
  logic [31:0]        r_data [LATENCY];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        r_data[s] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_err[0]   <= i_err;
      r_data[0]  <= i_data;
      for (int s = 1; s < LATENCY; s++) begin
        r_valid[s] <= r_valid[s-1];
        r_err[s]   <= r_err[s-1];
        r_data[s]  <= r_data[s-1];
      end
    end
  end

  assign o_valid = r_valid[LATENCY-1];
  assign o_err   = r_err[LATENCY-1];
  assign o_data  = r_data[LATENCY-1];

endmodule

// File: rtl/memory_pipelined.sv
// rtl/memory_pipelined.sv - dual-port big-endian byte RAM with pipelined responses
//
// Purpose: port I is a word-only read port, port D is a byte/half/word
// read/write port. Both accept a request every cycle and answer exactly
// LATENCY cycles later, flagging misaligned or out-of-range accesses.
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   i_req, i_addr                         port I request
//   i_rvalid, i_rdata, i_err              port I response
//   d_req, d_we, d_tsize, d_addr, d_wdata port D request
//   d_rvalid, d_rdata, d_err              port D response
module memory_pipelined
  import memory_pipelined_pkg::*;
#(
  parameter int N       = 1024,
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_rvalid,
  output logic [31:0]       i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic              d_we,
  input  tsize_e            d_tsize,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err
);

  localparam int MEM_AW = (N > 1) ? $clog2(N) : 1;

  logic [7:0] r_mem [N];

  logic              w_i_err;
  logic              w_d_err;
  logic [MEM_AW-1:0] w_i_idx0, w_i_idx1, w_i_idx2, w_i_idx3;
  logic [MEM_AW-1:0] w_d_idx0, w_d_idx1, w_d_idx2, w_d_idx3;
  logic [31:0]       w_i_word;
  logic [31:0]       w_d_rd;
  logic              w_d_wr_en;
  logic              w_i_pipe_err;
  logic [31:0]       w_i_pipe_data;
  logic              w_d_pipe_err;
  logic [31:0]       w_d_pipe_data;

  assign w_i_err = access_err(64'(i_addr), WORD, 64'(N));
  assign w_d_err = access_err(64'(d_addr), d_tsize, 64'(N));

  // Only the low MEM_AW bits index the array; any access that needs the
  // upper bits is out of range and never reaches memory.
  assign w_i_idx0 = i_addr[MEM_AW-1:0];
  assign w_i_idx1 = w_i_idx0 + MEM_AW'(1);
  assign w_i_idx2 = w_i_idx0 + MEM_AW'(2);
  assign w_i_idx3 = w_i_idx0 + MEM_AW'(3);
  assign w_d_idx0 = d_addr[MEM_AW-1:0];
  assign w_d_idx1 = w_d_idx0 + MEM_AW'(1);
  assign w_d_idx2 = w_d_idx0 + MEM_AW'(2);
  assign w_d_idx3 = w_d_idx0 + MEM_AW'(3);

  // Reads are combinational off the current array contents, so a write at
  // the same edge is not seen (read-first).
  assign w_i_word = {r_mem[w_i_idx0], r_mem[w_i_idx1], r_mem[w_i_idx2], r_mem[w_i_idx3]};

  always_comb begin
    w_d_rd = '0;
    case (d_tsize)
      BYTE:     w_d_rd = {24'h0, r_mem[w_d_idx0]};
      HALFWORD: w_d_rd = {16'h0, r_mem[w_d_idx0], r_mem[w_d_idx1]};
      WORD:     w_d_rd = {r_mem[w_d_idx0], r_mem[w_d_idx1], r_mem[w_d_idx2], r_mem[w_d_idx3]};
      default:  w_d_rd = '0;
    endcase
  end

  // A request presented during reset is dropped entirely, write included.
  assign w_d_wr_en = d_req && d_we && !w_d_err && !rst;

  always_ff @(posedge clk) begin
    if (w_d_wr_en) begin
      case (d_tsize)
        BYTE: begin
          r_mem[w_d_idx0] <= d_wdata[7:0];
        end
        HALFWORD: begin
          r_mem[w_d_idx0] <= d_wdata[15:8];
          r_mem[w_d_idx1] <= d_wdata[7:0];
        end
        WORD: begin
          r_mem[w_d_idx0] <= d_wdata[31:24];
          r_mem[w_d_idx1] <= d_wdata[23:16];
          r_mem[w_d_idx2] <= d_wdata[15:8];
          r_mem[w_d_idx3] <= d_wdata[7:0];
        end
        default: begin
        end
      endcase
    end
  end

  // Data is zeroed before entering the pipe so idle and error beats carry 0.
  assign w_i_pipe_err  = i_req && w_i_err;
  assign w_i_pipe_data = (i_req && !w_i_err) ? w_i_word : 32'h0;
  assign w_d_pipe_err  = d_req && w_d_err;
  assign w_d_pipe_data = (d_req && !w_d_err && !d_we) ? w_d_rd : 32'h0;

  mem_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_i_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (i_req),
    .i_err   (w_i_pipe_err),
    .i_data  (w_i_pipe_data),
    .o_valid (i_rvalid),
    .o_err   (i_err),
    .o_data  (i_rdata)
  );

  mem_rsp_pipe #(
    .LATENCY (LATENCY)
  ) u_d_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (d_req),
    .i_err   (w_d_pipe_err),
    .i_data  (w_d_pipe_data),
    .o_valid (d_rvalid),
    .o_err   (d_err),
    .o_data  (d_rdata)
  );

endmodule

// File: tb/tb_memory_pipelined.sv
// tb/tb_memory_pipelined.sv - scoreboard bench for memory_pipelined at LATENCY 1 and 3
module tb_memory_pipelined;
  import memory_pipelined_pkg::*;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 1: LATENCY=1, instance 3: LATENCY=3
  logic        i_req_1, i_req_3;
  logic [31:0] i_addr_1, i_addr_3;
  logic        i_rvalid_1, i_rvalid_3;
  logic [31:0] i_rdata_1, i_rdata_3;
  logic        i_err_1, i_err_3;
  logic        d_req_1, d_req_3;
  logic        d_we_1, d_we_3;
  tsize_e      d_tsize_1, d_tsize_3;
  logic [31:0] d_addr_1, d_addr_3;
  logic [31:0] d_wdata_1, d_wdata_3;
  logic        d_rvalid_1, d_rvalid_3;
  logic [31:0] d_rdata_1, d_rdata_3;
  logic        d_err_1, d_err_3;

  memory_pipelined #(.N(1024), .LATENCY(1), .ADDR_W(32)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req_1), .i_addr(i_addr_1),
    .i_rvalid(i_rvalid_1), .i_rdata(i_rdata_1), .i_err(i_err_1),
    .d_req(d_req_1), .d_we(d_we_1), .d_tsize(d_tsize_1), .d_addr(d_addr_1),
    .d_wdata(d_wdata_1),
    .d_rvalid(d_rvalid_1), .d_rdata(d_rdata_1), .d_err(d_err_1)
  );

  memory_pipelined #(.N(1024), .LATENCY(3), .ADDR_W(32)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req_3), .i_addr(i_addr_3),
    .i_rvalid(i_rvalid_3), .i_rdata(i_rdata_3), .i_err(i_err_3),
    .d_req(d_req_3), .d_we(d_we_3), .d_tsize(d_tsize_3), .d_addr(d_addr_3),
    .d_wdata(d_wdata_3),
    .d_rvalid(d_rvalid_3), .d_rdata(d_rdata_3), .d_err(d_err_3)
  );

  // port index: 0 = I@L1, 1 = D@L1, 2 = I@L3, 3 = D@L3
  logic        rv [4];
  logic        er [4];
  logic [31:0] rd [4];
  assign rv[0] = i_rvalid_1; assign er[0] = i_err_1; assign rd[0] = i_rdata_1;
  assign rv[1] = d_rvalid_1; assign er[1] = d_err_1; assign rd[1] = d_rdata_1;
  assign rv[2] = i_rvalid_3; assign er[2] = i_err_3; assign rd[2] = i_rdata_3;
  assign rv[3] = d_rvalid_3; assign er[3] = d_err_3; assign rd[3] = d_rdata_3;

  exp_t q [4][$];
  int   beats [4];
  int   n_total = 0;
  int   n_pass  = 0;

  initial for (int p = 0; p < 4; p++) beats[p] = 0;

  // Monitor: pops an expectation whenever a response beat appears, and
  // flags beats that are late, early, unexpected or non-zero while idle.
  always @(negedge clk) begin
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      if (rv[p]) begin
        beats[p] = beats[p] + 1;
        n_total = n_total + 1;
        if (q[p].size() == 0) begin
          $display("FAIL unexpected_rvalid port=%0d cyc=%0d err=%0b data=%08h required=no_beat",
                   p, cyc, er[p], rd[p]);
        end else begin
          e = q[p].pop_front();
          if (e.due != cyc || er[p] !== e.err || rd[p] !== e.data)
            $display("FAIL rsp port=%0d cyc=%0d err=%0b data=%08h required cyc=%0d err=%0b data=%08h",
                     p, cyc, er[p], rd[p], e.due, e.err, e.data);
          else
            n_pass = n_pass + 1;
        end
      end else begin
        n_total = n_total + 1;
        if (er[p] !== 1'b0 || rd[p] !== 32'h0)
          $display("FAIL idle_outputs port=%0d cyc=%0d err=%0b data=%08h required err=0 data=0",
                   p, cyc, er[p], rd[p]);
        else
          n_pass = n_pass + 1;
        if (q[p].size() > 0 && q[p][0].due <= cyc) begin
          e = q[p].pop_front();
          n_total = n_total + 1;
          $display("FAIL missing_rvalid port=%0d cyc=%0d rvalid=0 required beat due=%0d data=%08h",
                   p, cyc, e.due, e.data);
        end
      end
    end
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic push(input int p, input int l, input logic e_err, input logic [31:0] e_data);
    exp_t e;
    e.due  = cyc + l;
    e.err  = e_err;
    e.data = e_data;
    q[p].push_back(e);
  endtask

  task automatic d_op(input int k, input logic we, input tsize_e sz,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic e_err, input logic [31:0] e_data, input bit track);
    if (k == 0) begin
      d_req_1 = 1'b1; d_we_1 = we; d_tsize_1 = sz; d_addr_1 = addr; d_wdata_1 = wdata;
    end else begin
      d_req_3 = 1'b1; d_we_3 = we; d_tsize_3 = sz; d_addr_3 = addr; d_wdata_3 = wdata;
    end
    if (track) push(1 + 2 * k, lat(k), e_err, e_data);
  endtask

  task automatic i_op(input int k, input logic [31:0] addr,
                      input logic e_err, input logic [31:0] e_data, input bit track);
    if (k == 0) begin
      i_req_1 = 1'b1; i_addr_1 = addr;
    end else begin
      i_req_3 = 1'b1; i_addr_3 = addr;
    end
    if (track) push(2 * k, lat(k), e_err, e_data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    i_req_1 = 1'b0; d_req_1 = 1'b0;
    i_req_3 = 1'b0; d_req_3 = 1'b0;
  endtask

  int     snap_i, snap_d;
  tsize_e bad_sz;

  initial begin
    i_req_1 = 0; i_addr_1 = 0; d_req_1 = 0; d_we_1 = 0; d_tsize_1 = WORD; d_addr_1 = 0; d_wdata_1 = 0;
    i_req_3 = 0; i_addr_3 = 0; d_req_3 = 0; d_we_3 = 0; d_tsize_3 = WORD; d_addr_3 = 0; d_wdata_3 = 0;
    bad_sz = tsize_e'(2'b11);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // LATENCY=1 basic access
    d_op(0, 1, WORD,     32'h10, 32'hDEADBEEF, 0, 32'h0, 1);        tick();
    d_op(0, 0, WORD,     32'h10, 32'h0, 0, 32'hDEADBEEF, 1);        tick();
    d_op(0, 0, BYTE,     32'h11, 32'h0, 0, 32'h000000AD, 1);        tick();
    d_op(0, 0, HALFWORD, 32'h12, 32'h0, 0, 32'h0000BEEF, 1);
    i_op(0, 32'h10, 0, 32'hDEADBEEF, 1);                            tick();

    // misalignment
    d_op(0, 1, WORD,     32'h20, 32'hCAFEF00D, 0, 32'h0, 1);        tick();
    d_op(0, 1, WORD,     32'h22, 32'h12345678, 1, 32'h0, 1);        tick();
    d_op(0, 0, WORD,     32'h20, 32'h0, 0, 32'hCAFEF00D, 1);        tick();
    d_op(0, 0, HALFWORD, 32'h13, 32'h0, 1, 32'h0, 1);
    i_op(0, 32'h06, 1, 32'h0, 1);                                   tick();

    // range edges
    d_op(0, 1, WORD,     32'h3FC, 32'h0A0B0C0D, 0, 32'h0, 1);       tick();
    d_op(0, 0, WORD,     32'h3FC, 32'h0, 0, 32'h0A0B0C0D, 1);
    i_op(0, 32'h3FC, 0, 32'h0A0B0C0D, 1);                           tick();
    d_op(0, 0, WORD,     32'h400, 32'h0, 1, 32'h0, 1);
    i_op(0, 32'h400, 1, 32'h0, 1);                                  tick();
    d_op(0, 0, BYTE,     32'h3FF, 32'h0, 0, 32'h0000000D, 1);
    i_op(0, 32'hFFFFFFFC, 1, 32'h0, 1);                             tick();
    d_op(0, 0, WORD,     32'hFFFFFFFC, 32'h0, 1, 32'h0, 1);         tick();
    d_op(0, 0, HALFWORD, 32'h3FE, 32'h0, 0, 32'h00000C0D, 1);       tick();
    d_op(0, 0, HALFWORD, 32'h3FF, 32'h0, 1, 32'h0, 1);              tick();
    d_op(0, 0, BYTE,     32'h400, 32'h0, 1, 32'h0, 1);              tick();

    // illegal size encoding: error and no write
    d_op(0, 1, bad_sz,   32'h10, 32'h0, 1, 32'h0, 1);               tick();
    d_op(0, 0, WORD,     32'h10, 32'h0, 0, 32'hDEADBEEF, 1);        tick();

    // same-cycle collision, then sub-word writes
    d_op(0, 1, WORD,     32'h40, 32'h55667788, 0, 32'h0, 1);        tick();
    d_op(0, 1, WORD,     32'h40, 32'h11223344, 0, 32'h0, 1);
    i_op(0, 32'h40, 0, 32'h55667788, 1);                            tick();
    i_op(0, 32'h40, 0, 32'h11223344, 1);
    d_op(0, 1, BYTE,     32'h43, 32'hFFFFFF99, 0, 32'h0, 1);        tick();
    d_op(0, 0, WORD,     32'h40, 32'h0, 0, 32'h11223399, 1);        tick();
    d_op(0, 1, HALFWORD, 32'h40, 32'hAAAABBCC, 0, 32'h0, 1);        tick();
    d_op(0, 0, WORD,     32'h40, 32'h0, 0, 32'hBBCC3399, 1);        tick();

    // LATENCY=3 back-to-back
    d_op(1, 1, WORD, 32'h0, 32'h01020304, 0, 32'h0, 1);             tick();
    d_op(1, 1, WORD, 32'h4, 32'h05060708, 0, 32'h0, 1);             tick();
    d_op(1, 1, WORD, 32'h8, 32'h090A0B0C, 0, 32'h0, 1);             tick();
    d_op(1, 0, WORD, 32'h0, 32'h0, 0, 32'h01020304, 1);
    i_op(1, 32'h8, 0, 32'h090A0B0C, 1);                             tick();
    d_op(1, 0, WORD, 32'h4, 32'h0, 0, 32'h05060708, 1);
    i_op(1, 32'h4, 0, 32'h05060708, 1);                             tick();
    d_op(1, 0, WORD, 32'h8, 32'h0, 0, 32'h090A0B0C, 1);
    i_op(1, 32'h0, 0, 32'h01020304, 1);                             tick();
    repeat (5) tick();

    // reset mid-flight
    d_op(1, 1, WORD, 32'h100, 32'hA5A55A5A, 0, 32'h0, 1);           tick();
    repeat (4) tick();
    snap_i = beats[2];
    snap_d = beats[3];
    d_op(1, 0, WORD, 32'h100, 32'h0, 0, 32'h0, 0);
    i_op(1, 32'h100, 0, 32'h0, 0);                                  tick();
    d_op(1, 0, WORD, 32'h104, 32'h0, 0, 32'h0, 0);                  tick();
    rst = 1'b1;
    d_op(1, 0, WORD, 32'h100, 32'h0, 0, 32'h0, 0);                  tick();
    rst = 1'b0;
    repeat (5) tick();
    n_total = n_total + 1;
    if (beats[2] != snap_i || beats[3] != snap_d)
      $display("FAIL reset_flush i_beats=%0d d_beats=%0d required i_beats=%0d d_beats=%0d",
               beats[2], beats[3], snap_i, snap_d);
    else
      n_pass = n_pass + 1;
    d_op(1, 0, WORD, 32'h100, 32'h0, 0, 32'hA5A55A5A, 1);
    i_op(1, 32'h100, 0, 32'hA5A55A5A, 1);                           tick();
    repeat (6) tick();

    for (int p = 0; p < 4; p++) begin
      n_total = n_total + 1;
      if (q[p].size() != 0)
        $display("FAIL drained port=%0d pending=%0d required pending=0", p, q[p].size());
      else
        n_pass = n_pass + 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
